updown_mod_counter: RTL and testbench

//  Parametrised up/down modulo counter with built-in tick prescaler, for display/timer paths.

---
 rtl/updown_mod_counter_pkg.sv | 48 ++++
 rtl/updown_mod_counter_if.sv | 33 +++
 rtl/updown_mod_counter_tick_prescaler.sv | 30 +++
 rtl/updown_mod_counter.sv | 95 +++++++++
 tb/tb_updown_mod_counter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/updown_mod_counter_pkg.sv
// Shared types and helpers for the up/down modulo counter.
// Width/digit derivation and binary-to-BCD conversion.
package updown_mod_counter_pkg;

    typedef enum logic {DIR_DN = 1'b0, DIR_UP = 1'b1} dir_t;

    // Bits needed to hold 0..v.
    function automatic int clog2_w(input int v);
        int w;
        w = 1;
        while ((1 << w) < v + 1) w++;
        return w;
    endfunction

    // Decimal digits needed to show v.
    function automatic int ndig(input int v);
        int d;
        int x;
        d = 1;
        x = v;
        while (x >= 10) begin
            x = x / 10;
            d++;
        end
        return d;
    endfunction

    // Double-dabble into up to 8 digits; digits >= nd are zeroed.
    function automatic logic [31:0] bin2bcd(input logic [31:0] value,
                                            input int nd);
        logic [63:0] sh;
        logic [31:0] res;
        sh = {32'd0, value};
        for (int i = 0; i < 32; i++) begin
            for (int d = 0; d < 8; d++) begin
                if (sh[32+4*d +: 4] >= 4'd5)
                    sh[32+4*d +: 4] = sh[32+4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        res = sh[63:32];
        for (int d = 0; d < 8; d++) begin
            if (d >= nd) res[4*d +: 4] = 4'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulo counter.
// master drives start/ud/clear/load/load_val; slave returns count/bcd/flags.
interface updown_mod_counter_if
    import updown_mod_counter_pkg::*;
#(
    parameter int MAX_VAL = 99
);
    localparam int W    = clog2_w(MAX_VAL);
    localparam int NDIG = ndig(MAX_VAL);

    logic            start;
    logic            ud;
    logic            clear;
    logic            load;
    logic [W-1:0]    load_val;
    logic [W-1:0]    count;
    logic [4*NDIG-1:0] bcd;
    logic            tick;
    logic            tc;
    logic            at_max;
    logic            at_zero;

    modport master (
        output start, ud, clear, load, load_val,
        input  count, bcd, tick, tc, at_max, at_zero
    );

    modport slave (
        input  start, ud, clear, load, load_val,
        output count, bcd, tick, tc, at_max, at_zero
    );

endinterface

// File: rtl/updown_mod_counter_tick_prescaler.sv
// Free-running divider: tick pulses once every CLK_DIV cycles while en=1.
// Ports: clk, reset_n (async low), en, restart (sync zero), tick.
module tick_prescaler #(
    parameter int CLK_DIV = 12_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign tick    = en & at_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (!en || restart || at_last)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter 0..MAX_VAL with prescaled stepping, wrap/saturate.
// Ports: clk, reset_n (async low), bus (slave): controls in, count/bcd/tick/tc/at_max/at_zero out.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int CLK_DIV = 12_000_000,
    parameter int MAX_VAL = 99,
    parameter int WRAP    = 1
) (
    input  logic clk,
    input  logic reset_n,
    updown_mod_counter_if.slave bus
);
    localparam int W    = clog2_w(MAX_VAL);
    localparam int NDIG = ndig(MAX_VAL);
    localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         tc_q;
    logic         tc_d;
    logic         tick;
    logic         step;
    logic         at_max;
    logic         at_zero;
    logic [W-1:0] load_clamped;
    logic [31:0]  bcd_full;
    dir_t         dir;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (bus.start),
        .restart (bus.clear | bus.load),
        .tick    (tick)
    );

    assign step    = bus.start & tick;
    assign at_max  = (count_q == MAX_W);
    assign at_zero = (count_q == '0);
    assign dir     = bus.ud ? DIR_UP : DIR_DN;

    assign load_clamped = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.clear) begin
            count_d = (dir == DIR_UP) ? '0 : MAX_W;
        end else if (bus.load) begin
            count_d = load_clamped;
        end else if (step) begin
            unique case (dir)
                DIR_UP: begin
                    if (at_max) begin
                        tc_d    = 1'b1;
                        count_d = (WRAP != 0) ? '0 : count_q;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                DIR_DN: begin
                    if (at_zero) begin
                        tc_d    = 1'b1;
                        count_d = (WRAP != 0) ? MAX_W : count_q;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bcd_full    = bin2bcd(32'(count_q), NDIG);
    assign bus.bcd     = bcd_full[4*NDIG-1:0];
    assign bus.count   = count_q;
    assign bus.tick    = tick;
    assign bus.tc      = tc_q;
    assign bus.at_max  = at_max;
    assign bus.at_zero = at_zero;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: wrap, saturate and MAX_VAL=99 builds.
// All checks taken on the falling clock edge.
module tb_updown_mod_counter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic       a_start = 0, a_ud = 0, a_clear = 0, a_load = 0;
    logic [3:0] a_load_val = '0;
    logic       b_start = 0, b_ud = 0, b_clear = 0, b_load = 0;
    logic [3:0] b_load_val = '0;
    logic       c_start = 0, c_ud = 0, c_clear = 0, c_load = 0;
    logic [6:0] c_load_val = '0;

    updown_mod_counter_if #(.MAX_VAL(12)) a_if ();
    updown_mod_counter_if #(.MAX_VAL(12)) b_if ();
    updown_mod_counter_if #(.MAX_VAL(99)) c_if ();

    assign a_if.start = a_start;
    assign a_if.ud = a_ud;
    assign a_if.clear = a_clear;
    assign a_if.load = a_load;
    assign a_if.load_val = a_load_val;
    assign b_if.start = b_start;
    assign b_if.ud = b_ud;
    assign b_if.clear = b_clear;
    assign b_if.load = b_load;
    assign b_if.load_val = b_load_val;
    assign c_if.start = c_start;
    assign c_if.ud = c_ud;
    assign c_if.clear = c_clear;
    assign c_if.load = c_load;
    assign c_if.load_val = c_load_val;

    updown_mod_counter #(.CLK_DIV(4), .MAX_VAL(12), .WRAP(1)) u_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a_if.slave)
    );

    updown_mod_counter #(.CLK_DIV(4), .MAX_VAL(12), .WRAP(0)) u_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b_if.slave)
    );

    updown_mod_counter #(.CLK_DIV(2), .MAX_VAL(99), .WRAP(1)) u_c (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (c_if.slave)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset
        cyc(1);
        chk("rst_count", 32'(a_if.count), 0);
        chk("rst_tick", 32'(a_if.tick), 0);
        chk("rst_tc", 32'(a_if.tc), 0);
        chk("rst_bcd", 32'(a_if.bcd), 32'h00);
        chk("rst_zero", 32'(a_if.at_zero), 1);
        reset_n = 1'b1;
        cyc(20);
        chk("idle_count", 32'(a_if.count), 0);
        chk("idle_tick", 32'(a_if.tick), 0);

        // 2. count up with wrap
        a_start = 1;
        a_ud = 1;
        cyc(2);
        chk("first_tick_early", 32'(a_if.tick), 0);
        cyc(1);
        chk("first_tick", 32'(a_if.tick), 1);
        chk("first_tick_cnt", 32'(a_if.count), 0);
        cyc(1);
        chk("step1", 32'(a_if.count), 1);
        for (int k = 2; k <= 12; k++) begin
            cyc(4);
            chk("step_up", 32'(a_if.count), 32'(k));
        end
        chk("bcd12", 32'(a_if.bcd), 32'h12);
        chk("at_max12", 32'(a_if.at_max), 1);
        cyc(3);
        chk("pre_wrap_tc", 32'(a_if.tc), 0);
        cyc(1);
        chk("wrap_count", 32'(a_if.count), 0);
        chk("wrap_tc", 32'(a_if.tc), 1);
        cyc(1);
        chk("wrap_tc_end", 32'(a_if.tc), 0);

        // 4. load on a tick cycle, then clamp
        cyc(2);
        chk("load_tick", 32'(a_if.tick), 1);
        a_load = 1;
        a_load_val = 4'd7;
        cyc(1);
        a_load = 0;
        chk("load7", 32'(a_if.count), 7);
        chk("load7_tc", 32'(a_if.tc), 0);
        cyc(3);
        chk("load_hold", 32'(a_if.count), 7);
        cyc(1);
        chk("load_next", 32'(a_if.count), 8);
        a_load = 1;
        a_load_val = 4'd15;
        cyc(1);
        a_load = 0;
        chk("load_clamp", 32'(a_if.count), 12);

        // 5. clear, clear vs load, start freeze
        a_ud = 1;
        a_clear = 1;
        cyc(1);
        chk("clear_up", 32'(a_if.count), 0);
        a_ud = 0;
        cyc(1);
        chk("clear_dn", 32'(a_if.count), 12);
        a_ud = 1;
        a_load = 1;
        a_load_val = 4'd7;
        cyc(1);
        chk("clear_wins", 32'(a_if.count), 0);
        a_clear = 0;
        a_load = 0;
        cyc(2);
        a_start = 0;
        cyc(10);
        chk("freeze_cnt", 32'(a_if.count), 0);
        chk("freeze_tick", 32'(a_if.tick), 0);
        a_start = 1;
        cyc(2);
        chk("restart_early", 32'(a_if.tick), 0);
        cyc(1);
        chk("restart_tick", 32'(a_if.tick), 1);
        cyc(1);
        chk("restart_step", 32'(a_if.count), 1);

        // 3. saturate build
        b_ud = 0;
        b_start = 1;
        cyc(3);
        chk("sat_tick", 32'(b_if.tick), 1);
        chk("sat_tc0", 32'(b_if.tc), 0);
        cyc(1);
        chk("sat_hold0", 32'(b_if.count), 0);
        chk("sat_tc1", 32'(b_if.tc), 1);
        cyc(1);
        chk("sat_tc_end", 32'(b_if.tc), 0);
        cyc(3);
        chk("sat_hold0b", 32'(b_if.count), 0);
        chk("sat_tc2", 32'(b_if.tc), 1);
        b_ud = 1;
        cyc(4);
        chk("sat_up1", 32'(b_if.count), 1);
        chk("sat_up1_tc", 32'(b_if.tc), 0);
        cyc(4);
        chk("sat_up2", 32'(b_if.count), 2);
        b_load = 1;
        b_load_val = 4'd12;
        cyc(1);
        b_load = 0;
        chk("sat_load12", 32'(b_if.count), 12);
        cyc(4);
        chk("sat_hold12", 32'(b_if.count), 12);
        chk("sat_tc12", 32'(b_if.tc), 1);

        // MAX_VAL=99 wrap
        c_ud = 1;
        c_load = 1;
        c_load_val = 7'd98;
        cyc(1);
        c_load = 0;
        c_start = 1;
        chk("c_load98", 32'(c_if.count), 98);
        chk("c_bcd98", 32'(c_if.bcd), 32'h98);
        cyc(2);
        chk("c_count99", 32'(c_if.count), 99);
        chk("c_bcd99", 32'(c_if.bcd), 32'h99);
        cyc(2);
        chk("c_wrap", 32'(c_if.count), 0);
        chk("c_bcd00", 32'(c_if.bcd), 32'h00);
        chk("c_tc", 32'(c_if.tc), 1);
        c_start = 0;

        // 6. async reset between edges
        cyc(4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_count", 32'(a_if.count), 0);
        chk("async_tc", 32'(b_if.tc), 0);
        chk("async_b", 32'(b_if.count), 0);
        cyc(1);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
